// File: rtl/aes_block_seq_pkg.sv
// Shared definitions for the AES block sequencer: sequencer states, block geometry
// constants and the byte-swap helper between SRAM word order and AES byte order.
package aes_pkg;

  localparam int unsigned WORDS_PER_BLK = 4;
  localparam int unsigned BLK_CNT_W     = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_LAST,
    ST_LAUNCH,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } state_e;

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_block_seq_if.sv
// Bundle of control, SRAM and AesCore signals seen by the block sequencer.
// master = sequencer side, slave = environment (APB regs, SRAM, AesCore).
interface aes_block_seq_if #(
  parameter int unsigned AW = 9
);
  logic          iStart;
  logic [15:0]   iByteLen;
  logic [AW-1:0] iSrcBase;
  logic [AW-1:0] iDstBase;
  logic          oRdEn;
  logic [AW-1:0] oRdAddr;
  logic [31:0]   iRdData;
  logic          oStAes;
  logic [127:0]  oPlainText;
  logic          iAesDone;
  logic [127:0]  iCpText;
  logic          oWrEn;
  logic [AW-1:0] oWrAddr;
  logic [31:0]   oWrData;
  logic          oBusy;
  logic          oDone;
  logic [11:0]   oBlkCnt;

  modport master (
    input  iStart, iByteLen, iSrcBase, iDstBase, iRdData, iAesDone, iCpText,
    output oRdEn, oRdAddr, oStAes, oPlainText, oWrEn, oWrAddr, oWrData,
           oBusy, oDone, oBlkCnt
  );

  modport slave (
    output iStart, iByteLen, iSrcBase, iDstBase, iRdData, iAesDone, iCpText,
    input  oRdEn, oRdAddr, oStAes, oPlainText, oWrEn, oWrAddr, oWrData,
           oBusy, oDone, oBlkCnt
  );
endinterface

// File: rtl/aes_block_seq.sv
// Streams 16-byte blocks from SRAM through AesCore and back, byte-swapping words
// between SRAM order and AES order on the way in and out.
module aes_block_seq
  import aes_pkg::*;
#(
  parameter int unsigned AW = 9
) (
  input  logic            iClk,
  input  logic            iRst,
  aes_block_seq_if.master bus
);

  state_e                 state_q, state_d;
  logic [1:0]             idx_q, idx_d;
  logic [BLK_CNT_W-1:0]   rem_q, rem_d;
  logic [BLK_CNT_W-1:0]   blk_cnt_q, blk_cnt_d;
  logic [AW-1:0]          src_q, src_d;
  logic [AW-1:0]          dst_q, dst_d;
  logic [127:0]           pt_q, pt_d;
  logic [127:0]           ct_q, ct_d;
  logic [31:0]            ct_word;
  logic                   unused_len_low;

  assign unused_len_low = ^bus.iByteLen[3:0];

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      rem_q     <= '0;
      blk_cnt_q <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      pt_q      <= '0;
      ct_q      <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rem_q     <= rem_d;
      blk_cnt_q <= blk_cnt_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      pt_q      <= pt_d;
      ct_q      <= ct_d;
    end
  end

  always_comb begin
    ct_word = ct_q[127:96];
    case (idx_q)
      2'd0:    ct_word = ct_q[127:96];
      2'd1:    ct_word = ct_q[95:64];
      2'd2:    ct_word = ct_q[63:32];
      default: ct_word = ct_q[31:0];
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    blk_cnt_d = blk_cnt_q;
    src_d     = src_q;
    dst_d     = dst_q;
    pt_d      = pt_q;
    ct_d      = ct_q;
    bus.oRdEn   = 1'b0;
    bus.oRdAddr = '0;
    bus.oStAes  = 1'b0;
    bus.oWrEn   = 1'b0;
    bus.oWrAddr = '0;
    bus.oWrData = '0;
    bus.oDone   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.iStart) begin
          rem_d     = bus.iByteLen[15:4];
          src_d     = bus.iSrcBase;
          dst_d     = bus.iDstBase;
          blk_cnt_d = '0;
          idx_d     = '0;
          state_d   = (bus.iByteLen[15:4] != '0) ? ST_READ : ST_DONE;
        end
      end
      ST_READ: begin
        bus.oRdEn   = 1'b1;
        bus.oRdAddr = src_q + AW'(idx_q);
        // Read data lags the strobe by one cycle, so the first READ cycle has nothing to shift in.
        if (idx_q != 2'd0) pt_d = {pt_q[95:0], bswap(bus.iRdData)};
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = ST_LAST;
      end
      ST_LAST: begin
        pt_d    = {pt_q[95:0], bswap(bus.iRdData)};
        state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        bus.oStAes = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.iAesDone) begin
          ct_d    = bus.iCpText;
          idx_d   = '0;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        bus.oWrEn   = 1'b1;
        bus.oWrAddr = dst_q + AW'(idx_q);
        bus.oWrData = bswap(ct_word);
        idx_d       = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          blk_cnt_d = blk_cnt_q + 1'b1;
          rem_d     = rem_q - 1'b1;
          if (rem_q != BLK_CNT_W'(1)) begin
            src_d   = src_q + AW'(WORDS_PER_BLK);
            dst_d   = dst_q + AW'(WORDS_PER_BLK);
            state_d = ST_READ;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        bus.oDone = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.oBusy      = (state_q != ST_IDLE);
  assign bus.oPlainText = pt_q;
  assign bus.oBlkCnt    = blk_cnt_q;

endmodule

// File: tb/tb_aes_block_seq.sv
// Randomized scoreboard bench for aes_block_seq with an SRAM model and an AesCore stub
// whose ciphertext is the bitwise complement of the plaintext after a random latency.
module tb_aes_block_seq;

  localparam int unsigned AW = 9;
  localparam int unsigned MEMW = 512;

  logic iClk = 1'b0;
  logic iRst = 1'b1;
  always #5 iClk = ~iClk;

  aes_block_seq_if #(.AW(AW)) bus();

  aes_block_seq #(.AW(AW)) dut (
    .iClk(iClk),
    .iRst(iRst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  logic [31:0]     mem [MEMW];
  logic [AW-1:0]   exp_rd [$];
  logic [127:0]    exp_pt [$];
  logic [AW+31:0]  exp_wr [$];
  logic [11:0]     exp_done [$];

  int first_rd, first_st, done_cyc, last_wr, wr_seen;
  bit vec_run = 0;
  bit spurious_en = 0;
  int aes_cnt = 0;
  logic [127:0] aes_pt = '0;
  logic [31:0]  rd_pend = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // SRAM (1-cycle read latency) and AesCore stub, driven just after each edge.
  always @(posedge iClk) begin
    #1;
    bus.iRdData = rd_pend;
    rd_pend = bus.oRdEn ? mem[bus.oRdAddr] : $urandom;
    bus.iAesDone = 1'b0;
    bus.iCpText = {$urandom, $urandom, $urandom, $urandom};
    if (iRst) aes_cnt = 0;
    else if (aes_cnt > 0) begin
      aes_cnt--;
      if (aes_cnt == 0) begin
        bus.iAesDone = 1'b1;
        bus.iCpText = ~aes_pt;
      end
    end else if (spurious_en && bus.oRdEn) begin
      bus.iAesDone = 1'b1;
      spurious_en = 0;
    end
    if (bus.oStAes) begin
      check("single_launch", aes_cnt, 0);
      aes_cnt = $urandom_range(1, 20);
      aes_pt = bus.oPlainText;
    end
  end

  // Monitor: pops expectations whenever the DUT presents an output event.
  always @(posedge iClk) begin
    #1;
    if (bus.oRdEn) begin
      if (first_rd < 0) first_rd = cyc;
      if (exp_rd.size() == 0) check("rd_unexpected", 1, 0);
      else check("rd_addr", bus.oRdAddr, exp_rd.pop_front());
    end
    if (bus.oStAes) begin
      if (first_st < 0) first_st = cyc;
      if (exp_pt.size() == 0) check("launch_unexpected", 1, 0);
      else check("plaintext", bus.oPlainText, exp_pt.pop_front());
      if (vec_run) begin
        check("pt_vector", bus.oPlainText, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        vec_run = 0;
      end
    end
    if (bus.oWrEn) begin
      last_wr = cyc;
      wr_seen++;
      if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
      else check("wr_addr_data", {bus.oWrAddr, bus.oWrData}, exp_wr.pop_front());
    end
    if (bus.oDone) begin
      done_cyc = cyc;
      check("busy_at_done", bus.oBusy, 1);
      if (exp_done.size() == 0) check("done_unexpected", 1, 0);
      else check("blkcnt_at_done", bus.oBlkCnt, exp_done.pop_front());
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd"}, {bus.oRdEn, bus.oRdAddr}, 0);
    check({tag, "_st"}, bus.oStAes, 0);
    check({tag, "_pt"}, bus.oPlainText, 0);
    check({tag, "_wr"}, {bus.oWrEn, bus.oWrAddr, bus.oWrData}, 0);
    check({tag, "_busy_done"}, {bus.oBusy, bus.oDone}, 0);
    check({tag, "_blkcnt"}, bus.oBlkCnt, 0);
  endtask

  task automatic run(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                     input logic [15:0] len, input bit disturb, input bit rst_in_blk2);
    int n;
    int t0;
    bit pulsed;
    bit aborted;
    logic [127:0] pt;
    logic [31:0] w;
    logic [AW-1:0] a;
    n = int'(len[15:4]);
    pulsed = 0;
    aborted = 0;
    for (int b = 0; b < n; b++) begin
      pt = '0;
      for (int k = 0; k < 4; k++) begin
        a = AW'((int'(src) + 4 * b + k) % MEMW);
        exp_rd.push_back(a);
        w = mem[a];
        for (int j = 0; j < 4; j++) pt = {pt[119:0], w[8*j +: 8]};
        exp_wr.push_back({AW'((int'(dst) + 4 * b + k) % MEMW), ~w});
      end
      exp_pt.push_back(pt);
    end
    exp_done.push_back(12'(n));
    first_rd = -1; first_st = -1; done_cyc = -1; last_wr = -1; wr_seen = 0;
    spurious_en = disturb;

    @(posedge iClk); #2;
    bus.iSrcBase = src;
    bus.iDstBase = dst;
    bus.iByteLen = len;
    bus.iStart = 1'b1;
    t0 = cyc;
    @(posedge iClk); #2;
    bus.iStart = 1'b0;
    bus.iSrcBase = AW'($urandom);
    bus.iDstBase = AW'($urandom);
    bus.iByteLen = 16'($urandom);
    check("blkcnt_cleared", bus.oBlkCnt, 0);

    for (int c = 0; c < 3000 && done_cyc < 0 && !aborted; c++) begin
      if (disturb && !pulsed && aes_cnt > 0) begin
        bus.iStart = 1'b1;
        bus.iByteLen = 16'h0010;
        pulsed = 1;
        @(posedge iClk); #2;
        bus.iStart = 1'b0;
      end else if (rst_in_blk2 && wr_seen >= 4 && aes_cnt > 0) begin
        iRst = 1'b1;
        @(posedge iClk); #2;
        check_outputs_zero("reset_mid_run");
        iRst = 1'b0;
        exp_rd.delete(); exp_pt.delete(); exp_wr.delete(); exp_done.delete();
        aborted = 1;
      end else begin
        @(posedge iClk); #2;
      end
    end

    if (aborted) return;
    if (done_cyc < 0) begin
      check("done_timeout", 0, 1);
      return;
    end
    if (n == 0) begin
      check("done_latency_n0", done_cyc - t0, 1);
      check("no_rd_wr_n0", {first_rd == -1, wr_seen == 0}, 2'b11);
    end else begin
      check("first_rd_latency", first_rd - t0, 1);
      check("first_launch_latency", first_st - t0, 6);
      check("done_after_last_wr", done_cyc - last_wr, 1);
      check("write_count", wr_seen, 4 * n);
    end
    if (disturb) check("disturb_start_issued", pulsed, 1);
    @(posedge iClk); #2;
    check("idle_after_done", {bus.oBusy, bus.oDone}, 0);
    check("blkcnt_held", bus.oBlkCnt, n);
    check("queues_drained", exp_rd.size() + exp_pt.size() + exp_wr.size() + exp_done.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.iStart = 1'b0;
    bus.iByteLen = '0;
    bus.iSrcBase = '0;
    bus.iDstBase = '0;
    bus.iRdData = '0;
    bus.iAesDone = 1'b0;
    bus.iCpText = '0;
    for (int i = 0; i < MEMW; i++) mem[i] = $urandom;
    mem[0] = 32'h33221100;
    mem[1] = 32'h77665544;
    mem[2] = 32'hBBAA9988;
    mem[3] = 32'hFFEEDDCC;

    iRst = 1'b1;
    repeat (3) @(posedge iClk);
    #2;
    check_outputs_zero("reset");
    iRst = 1'b0;

    vec_run = 1;
    run(9'h000, 9'h100, 16'd16, 0, 0);
    run(9'h000, 9'h100, 16'd64, 0, 0);
    run(9'h010, 9'h110, 16'd0, 0, 0);
    run(9'h020, 9'h120, 16'h001F, 0, 0);
    run(9'h1FE, 9'h1FC, 16'd16, 0, 0);
    run(9'h040, 9'h140, 16'd48, 1, 0);
    run(9'h040, 9'h140, 16'd48, 0, 0);
    run(9'h080, 9'h180, 16'd64, 0, 1);
    run(9'h080, 9'h180, 16'd32, 0, 0);
    for (int r = 0; r < 6; r++)
      run(AW'($urandom), AW'($urandom), 16'($urandom_range(0, 95)), r[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
